// File: rtl/trigger_scheduler_if.sv
// Command/trigger bundle between the UART command path, the scheduler and the
// pulse generator. The scheduler uses the slave side.
interface trigger_scheduler_if;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       abort;
  logic       new_pattern;
  logic [1:0] pulse_rate;
  logic       busy;
  logic [2:0] fifo_count;
  logic       fifo_full;
  logic       cmd_drop;
  logic       seq_done;

  modport master (
    output cmd_valid, cmd_data, abort,
    input  new_pattern, pulse_rate, busy, fifo_count, fifo_full, cmd_drop, seq_done
  );

  modport slave (
    input  cmd_valid, cmd_data, abort,
    output new_pattern, pulse_rate, busy, fifo_count, fifo_full, cmd_drop, seq_done
  );
endinterface

// File: rtl/trigger_scheduler.sv
// Buffers command bytes in a small FIFO and expands each into a train of
// evenly spaced one-cycle trigger strobes for the pulse generator.
module trigger_scheduler #(
  parameter int WIDTH_0    = 27000,
  parameter int WIDTH_1    = 54000,
  parameter int WIDTH_2    = 135000,
  parameter int WIDTH_3    = 270000,
  parameter int GAP_0      = 0,
  parameter int GAP_1      = 27000,
  parameter int GAP_2      = 270000,
  parameter int GAP_3      = 2700000,
  parameter int GUARD      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              n_reset,
  trigger_scheduler_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, FIRE, WAIT} state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0]    count_q, count_d;
  logic          full, push, pop, drop;
  logic [7:0]    head;

  state_t        state_q;
  logic [4:0]    remain_q;
  logic [24:0]   wait_q;
  logic [24:0]   period_q;
  logic [1:0]    pulse_rate_q;
  logic          new_pattern_q;
  logic          seq_done_q;
  logic          cmd_drop_q;
  logic          aborted_q;

  function automatic logic [24:0] width_of(input logic [1:0] code);
    case (code)
      2'd0:    return 25'(WIDTH_0);
      2'd1:    return 25'(WIDTH_1);
      2'd2:    return 25'(WIDTH_2);
      default: return 25'(WIDTH_3);
    endcase
  endfunction

  function automatic logic [24:0] gap_of(input logic [1:0] code);
    case (code)
      2'd0:    return 25'(GAP_0);
      2'd1:    return 25'(GAP_1);
      2'd2:    return 25'(GAP_2);
      default: return 25'(GAP_3);
    endcase
  endfunction

  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign full = (count_q == 3'(FIFO_DEPTH));
  assign push = bus.cmd_valid && !bus.abort && !full;
  assign drop = bus.cmd_valid && (bus.abort || full);
  assign pop  = (state_q == LOAD);
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (bus.abort)
      count_d = '0;
    else if (push && !pop)
      count_d = count_q + 3'd1;
    else if (pop && !push)
      count_d = count_q - 3'd1;
  end

  always_ff @(posedge clock) begin
    if (push)
      mem_q[wr_ptr_q] <= bus.cmd_data;
  end

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cmd_drop_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      cmd_drop_q <= drop;
      if (bus.abort) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push)
          wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)
          rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  // The strobe cycle is the first of PERIOD; WAIT leaves when the counter hits 0.
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      state_q       <= IDLE;
      remain_q      <= '0;
      wait_q        <= '0;
      period_q      <= '0;
      pulse_rate_q  <= '0;
      new_pattern_q <= 1'b0;
      seq_done_q    <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      new_pattern_q <= 1'b0;
      seq_done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          aborted_q <= 1'b0;
          if (count_q != 3'd0 && !bus.abort)
            state_q <= LOAD;
        end
        LOAD: begin
          pulse_rate_q  <= head[1:0];
          remain_q      <= bus.abort ? 5'd0 : ({1'b0, head[5:2]} + 5'd1);
          period_q      <= width_of(head[1:0]) + 25'(GUARD) + gap_of(head[7:6]);
          new_pattern_q <= 1'b1;
          state_q       <= FIRE;
        end
        FIRE: begin
          remain_q <= (bus.abort || remain_q == 5'd0) ? 5'd0 : remain_q - 5'd1;
          wait_q   <= period_q - 25'd1;
          state_q  <= WAIT;
        end
        default: begin
          wait_q <= wait_q - 25'd1;
          if (bus.abort)
            remain_q <= '0;
          // seq_done must land in the final cycle of the period, one edge before IDLE.
          if (wait_q == 25'd2 && remain_q == 5'd0 && !aborted_q && !bus.abort)
            seq_done_q <= 1'b1;
          if (wait_q == 25'd1) begin
            if (remain_q != 5'd0 && !bus.abort) begin
              new_pattern_q <= 1'b1;
              state_q       <= FIRE;
            end else begin
              state_q <= IDLE;
            end
          end
        end
      endcase
      if (bus.abort && state_q != IDLE)
        aborted_q <= 1'b1;
    end
  end

  assign bus.new_pattern = new_pattern_q;
  assign bus.pulse_rate  = pulse_rate_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.fifo_count  = count_q;
  assign bus.fifo_full   = full;
  assign bus.cmd_drop    = cmd_drop_q;
  assign bus.seq_done    = seq_done_q;
endmodule
